// File: rtl/cache_core_req_dispatch.sv
// rtl/cache_core_req_dispatch.sv - steers per-lane core requests to cache banks
// Round-robin arbitration per bank, followed by a 2-entry skid buffer per bank.
module cache_core_req_dispatch #(
  parameter int NUM_BANKS       = 4,
  parameter int NUM_REQS        = 4,
  parameter int WORD_SIZE       = 4,
  parameter int WORD_ADDR_WIDTH = 30,
  parameter int CORE_TAG_WIDTH  = 8,
  localparam int WORD_WIDTH      = 8 * WORD_SIZE,
  localparam int BANK_SEL_BITS   = $clog2(NUM_BANKS),
  localparam int REQS_BITS       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int BANK_ADDR_WIDTH = WORD_ADDR_WIDTH - BANK_SEL_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQS-1:0]                     core_req_valid,
  input  logic [NUM_REQS-1:0]                     core_req_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]           core_req_byteen,
  input  logic [NUM_REQS*WORD_ADDR_WIDTH-1:0]     core_req_addr,
  input  logic [NUM_REQS*WORD_WIDTH-1:0]          core_req_data,
  input  logic [NUM_REQS*CORE_TAG_WIDTH-1:0]      core_req_tag,
  output logic [NUM_REQS-1:0]                     core_req_ready,
  output logic [NUM_BANKS-1:0]                    per_bank_core_req_valid,
  output logic [NUM_BANKS-1:0]                    per_bank_core_req_rw,
  output logic [NUM_BANKS*WORD_SIZE-1:0]          per_bank_core_req_byteen,
  output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0]    per_bank_core_req_addr,
  output logic [NUM_BANKS*WORD_WIDTH-1:0]         per_bank_core_req_data,
  output logic [NUM_BANKS*CORE_TAG_WIDTH-1:0]     per_bank_core_req_tag,
  output logic [NUM_BANKS*REQS_BITS-1:0]          per_bank_core_req_tid,
  input  logic [NUM_BANKS-1:0]                    per_bank_core_req_ready
);

  localparam int BSW      = (BANK_SEL_BITS > 0) ? BANK_SEL_BITS : 1;
  localparam int TAG_LSB  = REQS_BITS;
  localparam int DATA_LSB = TAG_LSB + CORE_TAG_WIDTH;
  localparam int ADDR_LSB = DATA_LSB + WORD_WIDTH;
  localparam int BE_LSB   = ADDR_LSB + BANK_ADDR_WIDTH;
  localparam int RW_BIT   = BE_LSB + WORD_SIZE;
  localparam int PW       = RW_BIT + 1;

  logic [BSW-1:0]       lane_bank [NUM_REQS];
  logic [PW-1:0]        lane_pld  [NUM_REQS];

  logic [REQS_BITS-1:0] win       [NUM_BANKS];
  logic [NUM_BANKS-1:0] found;
  logic [NUM_BANKS-1:0] push;
  logic [NUM_BANKS-1:0] pop;

  logic [REQS_BITS-1:0] ptr_q  [NUM_BANKS];
  logic [REQS_BITS-1:0] ptr_d  [NUM_BANKS];
  logic [PW-1:0]        main_q [NUM_BANKS];
  logic [PW-1:0]        main_d [NUM_BANKS];
  logic [PW-1:0]        skid_q [NUM_BANKS];
  logic [PW-1:0]        skid_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] main_vld_q, main_vld_d;
  logic [NUM_BANKS-1:0] skid_vld_q, skid_vld_d;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    logic [WORD_ADDR_WIDTH-1:0] addr_w;
    assign addr_w = core_req_addr[i*WORD_ADDR_WIDTH +: WORD_ADDR_WIDTH];
    if (BANK_SEL_BITS > 0) begin : g_sel
      assign lane_bank[i] = addr_w[BSW-1:0];
    end else begin : g_nosel
      assign lane_bank[i] = '0;
    end
    assign lane_pld[i] = {core_req_rw[i],
                          core_req_byteen[i*WORD_SIZE +: WORD_SIZE],
                          BANK_ADDR_WIDTH'(addr_w >> BANK_SEL_BITS),
                          core_req_data[i*WORD_WIDTH +: WORD_WIDTH],
                          core_req_tag[i*CORE_TAG_WIDTH +: CORE_TAG_WIDTH],
                          REQS_BITS'(i)};
  end

  // First valid lane for each bank, scanning upward from the bank's pointer.
  always_comb begin
    int idx;
    idx = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      win[b]   = '0;
      found[b] = 1'b0;
      for (int k = 0; k < NUM_REQS; k++) begin
        idx = int'(ptr_q[b]) + k;
        if (idx >= NUM_REQS) idx = idx - NUM_REQS;
        if (!found[b] && core_req_valid[idx] && lane_bank[idx] == BSW'(b)) begin
          found[b] = 1'b1;
          win[b]   = REQS_BITS'(idx);
        end
      end
    end
  end

  // full is the skid entry being occupied, so ready never waits on the bank.
  always_comb begin
    core_req_ready = '0;
    main_vld_d     = main_vld_q;
    skid_vld_d     = skid_vld_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      push[b]   = found[b] && !skid_vld_q[b];
      pop[b]    = main_vld_q[b] && per_bank_core_req_ready[b];
      ptr_d[b]  = ptr_q[b];
      main_d[b] = main_q[b];
      skid_d[b] = skid_q[b];
      if (push[b]) begin
        ptr_d[b] = (int'(win[b]) == NUM_REQS - 1) ? '0 : win[b] + REQS_BITS'(1);
        core_req_ready[win[b]] = 1'b1;
      end
      if (pop[b] && skid_vld_q[b]) begin
        main_d[b]     = skid_q[b];
        skid_vld_d[b] = 1'b0;
      end else if (pop[b] || !main_vld_q[b]) begin
        main_vld_d[b] = push[b];
        if (push[b]) main_d[b] = lane_pld[win[b]];
      end else if (push[b]) begin
        skid_d[b]     = lane_pld[win[b]];
        skid_vld_d[b] = 1'b1;
      end
    end
    if (reset) core_req_ready = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld_q <= '0;
      skid_vld_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        ptr_q[b]  <= '0;
        main_q[b] <= '0;
        skid_q[b] <= '0;
      end
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      for (int b = 0; b < NUM_BANKS; b++) begin
        ptr_q[b]  <= ptr_d[b];
        main_q[b] <= main_d[b];
        skid_q[b] <= skid_d[b];
      end
    end
  end

  assign per_bank_core_req_valid = main_vld_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_out
    assign per_bank_core_req_rw[b] = main_q[b][RW_BIT];
    assign per_bank_core_req_byteen[b*WORD_SIZE +: WORD_SIZE] = main_q[b][BE_LSB +: WORD_SIZE];
    assign per_bank_core_req_addr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] =
      main_q[b][ADDR_LSB +: BANK_ADDR_WIDTH];
    assign per_bank_core_req_data[b*WORD_WIDTH +: WORD_WIDTH] = main_q[b][DATA_LSB +: WORD_WIDTH];
    assign per_bank_core_req_tag[b*CORE_TAG_WIDTH +: CORE_TAG_WIDTH] =
      main_q[b][TAG_LSB +: CORE_TAG_WIDTH];
    assign per_bank_core_req_tid[b*REQS_BITS +: REQS_BITS] = main_q[b][REQS_BITS-1:0];
  end

endmodule
